apsk_symbol_lut: RTL and testbench

Programmable constellation mapper for the APSK modulator: it accepts symbol indices on an AXI-Stream input and emits the stored complex point {I,Q} on an AXI-Stream output. The table is loaded at run time through a third AXI-Stream port. It sits between the bit-slicing front end and the I/Q pulse-shaping filters.

---
 rtl/apsk_symbol_lut_pkg.sv | 17 +
 rtl/apsk_symbol_lut_if.sv | 12 +
 rtl/apsk_symbol_lut_ram.sv | 25 ++
 rtl/apsk_symbol_lut.sv | 80 ++++++++
 tb/tb_apsk_symbol_lut.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/apsk_symbol_lut_pkg.sv
// Shared constants and helpers for the APSK constellation mapper and its consumers.
package apsk_symbol_lut_pkg;

  localparam int TDATA_WIDTH_DEF   = 32;
  localparam int ADDRESS_WIDTH_DEF = 8;

  // I occupies the upper half-word, Q the lower half-word of each point.
  localparam int I_MSB = TDATA_WIDTH_DEF - 1;
  localparam int I_LSB = TDATA_WIDTH_DEF / 2;
  localparam int Q_MSB = TDATA_WIDTH_DEF / 2 - 1;
  localparam int Q_LSB = 0;

  function automatic int table_depth(input int address_width);
    return 1 << address_width;
  endfunction

endpackage

// File: rtl/apsk_symbol_lut_if.sv
// AXI-Stream bundle used for the index, load and output streams.
interface apsk_symbol_lut_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/apsk_symbol_lut_ram.sv
// Simple dual-port table RAM: synchronous write, synchronous read, read-before-write, no reset.
module apsk_symbol_lut_ram
  import apsk_symbol_lut_pkg::*;
#(
  parameter int DATA_WIDTH = TDATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [table_depth(ADDR_WIDTH)];

  // Write and read in the same process; non-blocking update returns the old word on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/apsk_symbol_lut.sv
// Programmable constellation mapper: index stream in, stored {I,Q} point out, table loaded over a stream.
module apsk_symbol_lut
  import apsk_symbol_lut_pkg::*;
#(
  parameter int TDATA_WIDTH   = TDATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                aclk,
  input  logic                areset,
  apsk_symbol_lut_if.slave    data_in,
  apsk_symbol_lut_if.slave    data_load,
  apsk_symbol_lut_if.master   data_out
);

  logic [ADDRESS_WIDTH-1:0] load_ptr;
  logic [TDATA_WIDTH-1:0]   rd_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     load_ready;
  logic                     has_data;
  logic                     in_fire;
  logic                     load_fire;
  logic                     out_fire;

  assign in_fire   = data_in.tvalid & data_in.tready;
  assign load_fire = data_load.tvalid & load_ready;
  assign out_fire  = out_valid & data_out.tready;

  assign data_in.tready   = !out_valid | data_out.tready;
  assign data_load.tready = load_ready;
  assign data_out.tvalid  = out_valid;
  assign data_out.tlast   = out_last;
  // The RAM read register has no reset; has_data forces the visible word to zero until the
  // first lookup after reset, so tdata still reads 0 out of reset and is cleared asynchronously.
  assign data_out.tdata   = has_data ? rd_data : '0;

  apsk_symbol_lut_ram #(
    .DATA_WIDTH (TDATA_WIDTH),
    .ADDR_WIDTH (ADDRESS_WIDTH)
  ) u_symbol_lut_ram (
    .clk     (aclk),
    .wr_en   (load_fire),
    .wr_addr (load_ptr),
    .wr_data (data_load.tdata),
    .rd_en   (in_fire),
    .rd_addr (data_in.tdata),
    .rd_data (rd_data)
  );

  // Load pointer: advance per accepted word, wrap naturally, return to 0 after a tlast word.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      load_ptr <= '0;
    end else if (load_fire) begin
      load_ptr <= data_load.tlast ? '0 : load_ptr + 1'b1;
    end
  end

  // Load ready is low during reset and held high afterwards.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) load_ready <= 1'b0;
    else        load_ready <= 1'b1;
  end

  // Output stage valid/tlast: load on input accept, drop on drain, hold while stalled.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      has_data  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_last  <= data_in.tlast;
      has_data  <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apsk_symbol_lut.sv
// Directed bench for the APSK constellation mapper.
module tb_apsk_symbol_lut;
  import apsk_symbol_lut_pkg::*;

  logic clk = 1'b0;
  logic areset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  apsk_symbol_lut_if #(.WIDTH(8))  in_if ();
  apsk_symbol_lut_if #(.WIDTH(32)) load_if ();
  apsk_symbol_lut_if #(.WIDTH(32)) out_if ();

  apsk_symbol_lut #(
    .TDATA_WIDTH   (32),
    .ADDRESS_WIDTH (8)
  ) dut (
    .aclk      (clk),
    .areset    (areset),
    .data_in   (in_if),
    .data_load (load_if),
    .data_out  (out_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_if.tvalid = 1'b1;
    load_if.tdata  = d;
    load_if.tlast  = last;
    @(negedge clk);
    load_if.tvalid = 1'b0;
    load_if.tlast  = 1'b0;
  endtask

  task automatic send(input logic [7:0] idx, input logic last);
    in_if.tvalid = 1'b1;
    in_if.tdata  = idx;
    in_if.tlast  = last;
    @(negedge clk);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0;
    load_if.tvalid = 1'b0; load_if.tdata = '0; load_if.tlast = 1'b0;
    out_if.tready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, out_if.tvalid}, 32'd0);
    chk("rst_tdata", out_if.tdata, 32'd0);
    chk("rst_tlast", {31'd0, out_if.tlast}, 32'd0);
    chk("rst_in_ready", {31'd0, in_if.tready}, 32'd1);
    chk("rst_load_ready", {31'd0, load_if.tready}, 32'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("load_ready_after", {31'd0, load_if.tready}, 32'd1);

    // Load four entries
    load_word(32'h00010002, 1'b0);
    load_word(32'h00030004, 1'b0);
    load_word(32'h00050006, 1'b0);
    load_word(32'h00070008, 1'b1);

    // Back-to-back lookups
    send(8'd3, 1'b0);
    chk("lk3_valid", {31'd0, out_if.tvalid}, 32'd1);
    chk("lk3_data", out_if.tdata, 32'h00070008);
    chk("lk3_last", {31'd0, out_if.tlast}, 32'd0);
    send(8'd0, 1'b0);
    chk("lk0_data", out_if.tdata, 32'h00010002);
    send(8'd2, 1'b0);
    chk("lk2_data", out_if.tdata, 32'h00050006);
    @(negedge clk);
    chk("drain_valid", {31'd0, out_if.tvalid}, 32'd0);

    // Stall with index 1 captured and index 2 waiting
    out_if.tready = 1'b0;
    send(8'd1, 1'b0);
    in_if.tvalid = 1'b1; in_if.tdata = 8'd2;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("stall_data", out_if.tdata, 32'h00030004);
      chk("stall_in_ready", {31'd0, in_if.tready}, 32'd0);
      @(negedge clk);
    end
    out_if.tready = 1'b1;
    @(negedge clk);
    in_if.tvalid = 1'b0;
    chk("release_data", out_if.tdata, 32'h00050006);
    chk("release_valid", {31'd0, out_if.tvalid}, 32'd1);
    @(negedge clk);
    chk("release_nodup", {31'd0, out_if.tvalid}, 32'd0);

    // tlast propagation
    send(8'd2, 1'b1);
    chk("tlast_beat", {31'd0, out_if.tlast}, 32'd1);
    send(8'd0, 1'b0);
    chk("tlast_next", {31'd0, out_if.tlast}, 32'd0);
    @(negedge clk);

    // Pointer returns to 0 after tlast
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b1);
    load_word(32'hAAAA5555, 1'b0);
    send(8'd0, 1'b0);
    chk("ptr_reset_e0", out_if.tdata, 32'hAAAA5555);
    send(8'd1, 1'b0);
    chk("ptr_reset_e1", out_if.tdata, 32'h22222222);

    // Same-cycle write and read of entry 1 (load_ptr is 1 here)
    load_if.tvalid = 1'b1; load_if.tdata = 32'h12345678; load_if.tlast = 1'b0;
    send(8'd1, 1'b0);
    load_if.tvalid = 1'b0;
    chk("rbw_old", out_if.tdata, 32'h22222222);
    send(8'd1, 1'b0);
    chk("rbw_new", out_if.tdata, 32'h12345678);
    @(negedge clk);

    // Asynchronous reset mid-stream
    out_if.tready = 1'b0;
    send(8'd3, 1'b0);
    chk("pre_rst_valid", {31'd0, out_if.tvalid}, 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("async_valid", {31'd0, out_if.tvalid}, 32'd0);
    chk("async_tdata", out_if.tdata, 32'd0);
    chk("async_load_ready", {31'd0, load_if.tready}, 32'd0);
    @(negedge clk);
    areset = 1'b0;
    out_if.tready = 1'b1;
    @(negedge clk);
    send(8'd3, 1'b0);
    chk("retain_e3", out_if.tdata, 32'h00070008);
    w = out_if.tdata;
    chk("retain_i", {16'd0, w[I_MSB:I_LSB]}, 32'h00000007);
    chk("retain_q", {16'd0, w[Q_MSB:Q_LSB]}, 32'h00000008);
    send(8'd2, 1'b0);
    chk("retain_e2", out_if.tdata, 32'h00050006);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
